load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state rising-edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: req_valid in 1 request present; req_ready out 1 unit can accept; req_we in 1 1=store, 0=load.
REQ-004 SHALL have ports: req_funct3 in 3 RISC-V size/sign code; req_addr in 32 byte address; req_wdata in 32 store data, LSB-aligned.
REQ-005 SHALL have ports: resp_valid out 1 response present; resp_ready in 1 consumer accepts; resp_rdata out 32 load result; resp_err out 1 request rejected.
REQ-006 SHALL have memory-side ports: mem_we out 1 word write strobe; mem_addr out 14 byte address; mem_wdata out 32 write word; mem_rdata in 32 combinational read word for mem_addr.

Function
REQ-007 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL latch we, funct3, addr and wdata on the req_valid and req_ready cycle.
REQ-009 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores as 000 SB, 001 SH, 010 SW; any other code SHALL be an error.
REQ-010 SHALL treat halfword with addr[0]=1, or word with addr[1:0]!=0, as misaligned error.
REQ-011 SHALL, on error, go IDLE->RESP with resp_err=1, resp_rdata=0 and no memory access.
REQ-012 SHALL go IDLE->RD for loads and SB/SH (read-modify-write), and IDLE->WR for SW.
REQ-013 SHALL in RD drive mem_addr=latched addr[13:0] with mem_we=0, and capture mem_rdata.
REQ-014 SHALL make RD go to RESP for loads and to WR for stores.
REQ-015 SHALL for loads select byte lane addr[1:0] or halfword lane addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-016 SHALL for SB/SH replace only the addressed lane of the captured word with req_wdata[7:0] or [15:0].
REQ-017 SHALL in WR assert mem_we=1 for exactly one cycle, with mem_addr=latched addr[13:0] and mem_wdata=merged word (SW: wdata), then go to RESP.
REQ-018 SHALL hold resp_valid=1 with stable resp_rdata and resp_err in RESP until resp_ready=1, then go to IDLE.
REQ-019 SHALL drive store responses with resp_rdata=0 and resp_err=0.
REQ-020 SHALL drive mem_addr=0 and mem_wdata=0 outside RD and WR, and mem_we=0 outside WR.
REQ-021 SHALL give these latencies, counted in cycles from accept to first resp_valid: LW/LB/LH/LBU/LHU 2, SW 2, SB/SH 3, error 1.
REQ-022 SHALL accept no new request before the RESP handshake completes; back-to-back requests SHALL get no overlap.

Reset
REQ-023 SHALL make rst_n low force, asynchronously, state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, and all latched fields=0.
REQ-024 SHALL ensure that reset asserted during WR before the clock edge produces no memory write, and reset during RESP drops the pending response.
REQ-025 SHALL make req_ready=1 on the first cycle after rst_n deasserts.

Configuration
REQ-026 SHALL support macro LSU_BOUNDS_CHECK_EN.
REQ-027 SHALL, when LSU_BOUNDS_CHECK_EN is defined, treat req_addr[31:14]!=0 as an error handled per REQ-011.
REQ-028 SHALL, when LSU_BOUNDS_CHECK_EN is undefined, ignore req_addr[31:14], so addresses wrap modulo 16 KB.

Verification
REQ-029 SHALL cover: memory word at byte 0x14 = 0xABCDEF01; LB 0x14 -> resp_rdata 0x00000001; LB 0x17 -> 0xFFFFFFAB; LBU 0x17 -> 0x000000AB; each with resp_valid 2 cycles after accept.
REQ-030 SHALL cover: LH 0x16 -> 0xFFFFABCD; LHU 0x14 -> 0x0000EF01; LW 0x14 -> 0xABCDEF01.
REQ-031 SHALL cover: SB 0x15 wdata 0x12345655 -> single mem_we pulse in cycle 2, word becomes 0xABCD5501, resp_valid at cycle 3; then LW 0x14 -> 0xABCD5501.
REQ-032 SHALL cover: LW 0x16, SH 0x15, or funct3=011 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, mem_we never asserted.
REQ-033 SHALL cover: SW 0x20 wdata 0xDEADBEEF with rst_n pulsed low during WR -> mem_we drops immediately, word 0x20 unchanged, req_ready=1 after release.
REQ-034 SHALL cover: resp_ready held low 5 cycles -> resp_valid/resp_rdata stable and req_ready=0 throughout; and LW 0x00004014 -> resp_err=1 with LSU_BOUNDS_CHECK_EN, 0xABCD5501 (from REQ-031) without.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit over a 16 KB word-wide memory, with read-modify-write for SB/SH.
// Optional build macro LSU_BOUNDS_CHECK_EN rejects requests whose address has any of bits [31:14] set.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 32;
  localparam int unsigned HW  = 16;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [AW-1:0]   addr_q;
  logic [HW-1:0]   wdata_q;

  logic            req_ready_d;
  logic            resp_valid_d, resp_err_d;
  logic [DW-1:0]   resp_rdata_d;
  logic            mem_we_d;
  logic [AW-1:0]   mem_addr_d;
  logic [DW-1:0]   mem_wdata_d;
  logic            accept_c;
  logic            req_err_c;
  logic            addr_oob_c;

`ifdef LSU_BOUNDS_CHECK_EN
  assign addr_oob_c = |req_addr[DW-1:AW];
`else
  logic unused_addr_hi;
  assign addr_oob_c     = 1'b0;
  assign unused_addr_hi = ^req_addr[DW-1:AW];
`endif

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [DW-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [DW-1:0] w);
    logic [7:0]    b;
    logic [HW-1:0] h;
    logic [DW-1:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overlay the store data onto the addressed lane of the current word.
  function automatic logic [DW-1:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [DW-1:0] w, input logic [HW-1:0] wd);
    logic [DW-1:0] r;
    r = w;
    case (f3)
      F3_B: r[{a, 3'b000} +: 8] = wd[7:0];
      F3_H: if (a[1]) r[31:16] = wd; else r[15:0] = wd;
      default: r = w;
    endcase
    return r;
  endfunction

  // Illegal size code, misalignment or out-of-range address.
  always_comb begin
    logic code_ok;
    logic misaligned;
    code_ok    = req_we ? (req_funct3 inside {F3_B, F3_H, F3_W})
                        : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err_c  = !code_ok || misaligned || addr_oob_c;
  end

  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (req_err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we || (req_funct3 != F3_W)) begin
            state_d    = RD;
            mem_addr_d = req_addr[AW-1:0];
          end else begin
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr[AW-1:0];
            mem_wdata_d = req_wdata;
          end
        end
      end
      RD: begin
        if (!we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extract(funct3_q, addr_q[1:0], mem_rdata);
        end else begin
          state_d     = WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = store_merge(funct3_q, addr_q[1:0], mem_rdata, wdata_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = resp_err;
          resp_rdata_d = resp_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if (accept_c) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[AW-1:0];
        wdata_q  <= req_wdata[HW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-addressed reference memory predicts each response.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // DUT-side word memory
  logic [31:0] mem [4096];
  logic [1:0]  unused_mem_addr_lo;
  assign unused_mem_addr_lo = mem_addr[1:0];
  assign mem_rdata = mem[mem_addr[13:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] = mem_wdata;

  // Reference model: flat byte array
  logic [7:0] ref_mem [16384];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int cyc = 0, issued = 0, done_cnt = 0, wr_count = 0;
  bit in_resp = 0, hold_lo = 0;
  logic [31:0] held_rdata;
  logic        held_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd);
    exp_t e;
    int a, sz;
    bit ok;
    logic [31:0] v;
    a  = int'(addr % 32'd16384);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (a % sz != 0) ok = 0;
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr >= 32'd16384) ok = 0;
`endif
    e.rdata = 0; e.err = 0; e.writes = 0; e.acc = 0;
    if (!ok) begin
      e.err = 1; e.lat = 1;
    end else if (!we) begin
      v = 0;
      for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
      if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v; e.lat = 2;
    end else begin
      for (int k = 0; k < sz; k++) ref_mem[a + k] = 8'(wd >> (8 * k));
      e.writes = 1; e.lat = (sz == 4) ? 2 : 3;
    end
    return e;
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  task automatic issue_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit track);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_before_issue", 32'(req_ready), 32'd1);
    if (track) begin
      e = model(we, f3, addr, wd);
      e.acc = cyc;
      sb.push_back(e);
      issued++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < issued && n < 100) begin @(negedge clk); n++; end
    check("response_handshake", 32'(done_cnt), 32'(issued));
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    issue_req(we, f3, addr, wd, 1'b1);
    wait_done();
  endtask

  // Consumer backpressure
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      resp_ready = hold_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  always @(posedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      done_cnt++;
      in_resp = 0;
    end
  end

  // Monitor: compare each new response against the scoreboard, then check it stays stable
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      wr_count = 0;
      in_resp  = 0;
    end else begin
      if (mem_we) wr_count++;
      if (resp_valid && !in_resp) begin
        if (sb.size() == 0) begin
          check("unexpected_response", 32'(resp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("mem_we_pulses", 32'(wr_count), 32'(e.writes));
        end
        wr_count   = 0;
        in_resp    = 1;
        held_rdata = resp_rdata;
        held_err   = resp_err;
      end else if (resp_valid && in_resp) begin
        check("held_rdata", resp_rdata, held_rdata);
        check("held_err", 32'(resp_err), 32'(held_err));
        check("req_ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, a;
    logic [2:0]  f3;
    int n;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = w[8 * k +: 8];
    end
    mem[5] = 32'hABCD_EF01;
    ref_mem[20] = 8'h01; ref_mem[21] = 8'hEF; ref_mem[22] = 8'hCD; ref_mem[23] = 8'hAB;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Directed loads on word 0x14
    txn(1'b0, 3'b000, 32'h14, 32'h0);
    txn(1'b0, 3'b000, 32'h17, 32'h0);
    txn(1'b0, 3'b100, 32'h17, 32'h0);
    txn(1'b0, 3'b001, 32'h16, 32'h0);
    txn(1'b0, 3'b101, 32'h14, 32'h0);
    txn(1'b0, 3'b010, 32'h14, 32'h0);
    // Byte store with read-modify-write, then read back
    txn(1'b1, 3'b000, 32'h15, 32'h1234_5655);
    txn(1'b0, 3'b010, 32'h14, 32'h0);
    check("word_0x14_after_sb", mem[5], 32'hABCD_5501);
    // Errors
    txn(1'b0, 3'b010, 32'h16, 32'h0);
    txn(1'b1, 3'b001, 32'h15, 32'hFFFF_FFFF);
    txn(1'b0, 3'b011, 32'h14, 32'h0);

    // Backpressure: response held for 5 cycles
    hold_lo = 1;
    issue_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("resp_valid_under_backpressure", 32'(resp_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    hold_lo = 0;
    wait_done();

    // Reset during the write cycle of SW 0x20
    w = mem[8];
    issue_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0);
    check("sw_mem_we_in_wr", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mem_we_drop", 32'(mem_we), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_mid_reset", 32'(req_ready), 32'd1);
    check("word_0x20_unchanged", mem[8], w);
    check("word_0x20_model", mem[8], ref_word(32));
    txn(1'b0, 3'b010, 32'h20, 32'h0);

    // High address bits: error with bounds check, wrap to 0x14 without
    txn(1'b0, 3'b010, 32'h0000_4014, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 16383));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << 14);
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63));
      f3 = 3'($urandom_range(0, 7));
      txn(1'($urandom_range(0, 1)), f3, a, $urandom);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
